read_control_logic: RTL and testbench

//  Read-side controller for the dual-clock FIFO design example; counterpart of the write controller.

---
 rtl/read_control_logic.sv | 97 +++++++++
 tb/tb_read_control_logic.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_control_logic.sv
// Read-side controller for the dual-clock FIFO example: drains NUM_WORDS words, checks them
// against the writer's incrementing pattern and reports captures, mismatches and completion.
module read_control_logic #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 256,
  parameter int ERR_W     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rdempty_i,
  input  logic [DATA_W-1:0] q_i,
  output logic              rdreq_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              err_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [ADDR_W:0] word_cnt;
  logic            mismatch;
  logic            last_word;
  logic            state_ok;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign mismatch  = (q_i != DATA_W'(addr_o));
  assign last_word = (word_cnt == LAST_IDX);
  assign state_ok  = state inside {IDLE, READ, CAPTURE, WAIT, DONE};

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = rdempty_i ? IDLE : READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: begin
        if (last_word)       state_nxt = DONE;
        else if (!rdempty_i) state_nxt = READ;
        else                 state_nxt = WAIT;
      end
      WAIT:    state_nxt = rdempty_i ? WAIT : READ;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdreq_o = (state == READ);
    done_o  = (state == DONE);
  end

  // capture stage: q_i arrives one cycle after the READ request
  always_ff @(posedge clk_i) begin
    if (reset_i || !state_ok) begin
      addr_o    <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      word_cnt  <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state == CAPTURE) begin
        data_o   <= q_i;
        valid_o  <= 1'b1;
        addr_o   <= addr_o + ADDR_W'(1);
        word_cnt <= word_cnt + (ADDR_W + 1)'(1);
        if (mismatch) begin
          err_o     <= 1'b1;
          err_cnt_o <= sat_inc(err_cnt_o);
        end
      end
    end
  end

endmodule

// File: tb/tb_read_control_logic.sv
// Bench for read_control_logic: a behavioural FIFO feeds the controller, and captured words,
// error flags and counts are compared against a word-list reference model.
module tb_read_control_logic;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NUM_WORDS = 256;
  localparam int ERR_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic              rdempty_i;
  logic              hold_empty;
  logic              flush_req;
  logic [DATA_W-1:0] q_i;

  logic              rdreq_o, valid_o, err_o, done_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic [ERR_W-1:0]  err_cnt_o;

  logic              rdreq1, valid1, err1, done1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic [1:0]        errcnt1;

  read_control_logic #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .ERR_W(ERR_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .rdempty_i(rdempty_i), .q_i(q_i), .rdreq_o(rdreq_o),
    .addr_o(addr_o), .data_o(data_o), .valid_o(valid_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .done_o(done_o));

  read_control_logic #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .ERR_W(2)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .rdempty_i(rdempty_i), .q_i(q_i), .rdreq_o(rdreq1),
    .addr_o(addr1), .data_o(data1), .valid_o(valid1), .err_o(err1), .err_cnt_o(errcnt1),
    .done_o(done1));

  // FIFO model: words pushed by the tests, popped on rdreq_o, q_i valid the next cycle
  logic [31:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int run_base = 0;
  assign rdempty_i = hold_empty || (rd_ptr >= wr_ptr);

  always @(posedge clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (rdreq_o) begin
      q_i    <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [31:0]      cap_data[$];
  bit               cap_err[$];
  logic [ERR_W-1:0] cap_ecnt[$];
  int cyc = 0, last_req = -100, min_gap = 1000, rdreq_cnt = 0, rdreq1_cnt = 0, valid1_cnt = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_i) begin
      cap_data.delete();
      cap_err.delete();
      cap_ecnt.delete();
      last_req   <= -100;
      min_gap    <= 1000;
      rdreq_cnt  <= 0;
      rdreq1_cnt <= 0;
      valid1_cnt <= 0;
    end else begin
      if (valid_o) begin
        cap_data.push_back(data_o);
        cap_err.push_back(err_o);
        cap_ecnt.push_back(err_cnt_o);
      end
      if (rdreq_o) begin
        rdreq_cnt <= rdreq_cnt + 1;
        if (cyc - last_req < min_gap) min_gap <= cyc - last_req;
        last_req <= cyc;
      end
      if (rdreq1) rdreq1_cnt <= rdreq1_cnt + 1;
      if (valid1) valid1_cnt <= valid1_cnt + 1;
    end
  end

  int tests_run = 0;
  int fails = 0;

  // mismatches among the first 'upto' words of a run, saturated to an errw-bit counter
  function automatic int model_errs(input int base, input int upto, input int errw);
    int c = 0;
    int mx = (1 << errw) - 1;
    for (int k = 0; k < upto; k++)
      if (mem[base + k] !== 32'(k % (1 << ADDR_W))) c++;
    return (c > mx) ? mx : c;
  endfunction

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_i = 1'b1; flush_req = 1'b1; hold_empty = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0; flush_req = 1'b0;
    run_base = wr_ptr;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_caps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cap_data.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; flush_req = 1'b1; hold_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset_i = 1'b0; flush_req = 1'b0;
    tests_run++; if (rdreq_o !== 1'b0) begin fails++; $display("FAIL reset_rdreq: got %0b want 0", rdreq_o); end
    tests_run++; if (addr_o !== '0) begin fails++; $display("FAIL reset_addr: got %0h want 0", addr_o); end
    tests_run++; if (data_o !== '0) begin fails++; $display("FAIL reset_data: got %0h want 0", data_o); end
    tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err_o); end
    tests_run++; if (err_cnt_o !== '0) begin fails++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt_o); end
    tests_run++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done_o); end
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (rdreq_cnt != 0 || addr_o !== '0) begin
      fails++; $display("FAIL idle_empty: rdreq pulses %0d addr %0h, want 0 and 0", rdreq_cnt, addr_o);
    end
  endtask

  task automatic test_full_drain();
    bit ok;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < NUM_WORDS; i++) push_word(32'(i));
    wait_done(1500, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL full_timeout: done_o %0b want 1", done_o); end
    tests_run++; if (valid_o !== 1'b1) begin fails++; $display("FAIL full_done_with_last: valid_o %0b want 1", valid_o); end
    @(posedge clk); #1;
    for (int k = 0; k < cap_data.size(); k++) if (cap_data[k] !== mem[run_base + k]) bad++;
    tests_run++; if (cap_data.size() != NUM_WORDS || bad != 0) begin
      fails++; $display("FAIL full_seq: got %0d words (%0d wrong) want %0d words", cap_data.size(), bad, NUM_WORDS);
    end
    tests_run++; if (rdreq_cnt != NUM_WORDS || min_gap != 2) begin
      fails++; $display("FAIL full_rdreq: pulses %0d min gap %0d, want %0d and 2", rdreq_cnt, min_gap, NUM_WORDS);
    end
    tests_run++; if (err_o !== 1'b0 || err_cnt_o !== '0) begin
      fails++; $display("FAIL full_err: err %0b cnt %0d want 0 0", err_o, err_cnt_o);
    end
    tests_run++; if (addr_o !== '0 || data_o !== 32'd255 || done_o !== 1'b1) begin
      fails++; $display("FAIL full_final: addr %0h data %0h done %0b want 0 ff 1", addr_o, data_o, done_o);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad = 0;
    apply_reset();
    for (int i = 0; i <= 10; i++) push_word(32'(i));
    wait_caps(11, 200, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL stall_first11: got %0d words want 11", cap_data.size()); end
    hold_empty = 1'b1;
    for (int i = 11; i < NUM_WORDS; i++) push_word(32'(i));
    repeat (20) @(posedge clk);
    #1;
    tests_run++; if (rdreq_cnt != 11 || cap_data.size() != 11) begin
      fails++; $display("FAIL stall_hold: pulses %0d words %0d want 11 11", rdreq_cnt, cap_data.size());
    end
    for (int c = 0; c < 3000 && !done_o; c++) begin
      hold_empty = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    hold_empty = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (done_o !== 1'b1) begin fails++; $display("FAIL stall_done: got %0b want 1", done_o); end
    tests_run++; if (cap_data.size() < 12 || cap_data[11] !== 32'd11) begin
      fails++; $display("FAIL stall_resume: words %0d, want word 11 after the stall", cap_data.size());
    end
    for (int k = 0; k < cap_data.size(); k++) if (cap_data[k] !== mem[run_base + k]) bad++;
    tests_run++; if (cap_data.size() != NUM_WORDS || bad != 0 || rdreq_cnt != NUM_WORDS || min_gap < 2) begin
      fails++; $display("FAIL stall_seq: words %0d wrong %0d pulses %0d gap %0d want %0d 0 %0d >=2",
                        cap_data.size(), bad, rdreq_cnt, min_gap, NUM_WORDS, NUM_WORDS);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    int bad = 0;
    int exp_cnt;
    apply_reset();
    for (int i = 0; i < NUM_WORDS; i++) push_word((i == 5 || i == 200) ? 32'hDEAD_BEEF : 32'(i));
    wait_done(1500, ok);
    @(posedge clk); #1;
    exp_cnt = model_errs(run_base, NUM_WORDS, ERR_W);
    tests_run++; if (!ok || cap_data.size() != NUM_WORDS) begin
      fails++; $display("FAIL corrupt_all_read: words %0d want %0d", cap_data.size(), NUM_WORDS);
    end
    tests_run++; if (cap_data.size() < 6 || cap_err[4] !== 1'b0 || cap_err[5] !== 1'b1) begin
      fails++; $display("FAIL corrupt_err_rise: err at word 4/5 wrong, want 0 then 1");
    end
    for (int k = 0; k < cap_data.size(); k++)
      if (cap_data[k] !== mem[run_base + k] || cap_ecnt[k] !== ERR_W'(model_errs(run_base, k + 1, ERR_W)) ||
          cap_err[k] !== (model_errs(run_base, k + 1, ERR_W) > 0)) bad++;
    tests_run++; if (bad != 0) begin fails++; $display("FAIL corrupt_per_word: %0d words wrong want 0", bad); end
    tests_run++; if (err_cnt_o !== ERR_W'(exp_cnt) || err_o !== 1'b1) begin
      fails++; $display("FAIL corrupt_count: cnt %0d err %0b want %0d 1", err_cnt_o, err_o, exp_cnt);
    end
  endtask

  task automatic test_done_hold();
    int exp_cnt = model_errs(run_base, NUM_WORDS, ERR_W);
    for (int i = 0; i < 50; i++) push_word(32'(i));
    repeat (50) @(posedge clk);
    #1;
    tests_run++; if (rdreq_cnt != NUM_WORDS || cap_data.size() != NUM_WORDS) begin
      fails++; $display("FAIL done_no_rdreq: pulses %0d words %0d want %0d", rdreq_cnt, cap_data.size(), NUM_WORDS);
    end
    tests_run++; if (data_o !== mem[run_base + NUM_WORDS - 1] || addr_o !== '0 || done_o !== 1'b1) begin
      fails++; $display("FAIL done_frozen: data %0h addr %0h done %0b want %0h 0 1",
                        data_o, addr_o, done_o, mem[run_base + NUM_WORDS - 1]);
    end
    tests_run++; if (err_cnt_o !== ERR_W'(exp_cnt) || err_o !== (exp_cnt > 0)) begin
      fails++; $display("FAIL done_err_frozen: cnt %0d err %0b want %0d", err_cnt_o, err_o, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < NUM_WORDS; i++) push_word((i == 3) ? 32'h1234_5678 : 32'(i));
    wait_caps(100, 500, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL midrst_reach100: words %0d want 100", cap_data.size()); end
    apply_reset();
    tests_run++; if (rdreq_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b0 || addr_o !== '0 ||
                     data_o !== '0 || err_o !== 1'b0 || err_cnt_o !== '0) begin
      fails++; $display("FAIL midrst_clear: rdreq %0b valid %0b done %0b addr %0h data %0h err %0b cnt %0d want all 0",
                        rdreq_o, valid_o, done_o, addr_o, data_o, err_o, err_cnt_o);
    end
    for (int i = 0; i < NUM_WORDS; i++) push_word(32'(i));
    wait_done(1500, ok);
    @(posedge clk); #1;
    for (int k = 0; k < cap_data.size(); k++) if (cap_data[k] !== mem[run_base + k]) bad++;
    tests_run++; if (!ok || cap_data.size() != NUM_WORDS || bad != 0 || err_o !== 1'b0 || err_cnt_o !== '0) begin
      fails++; $display("FAIL midrst_refill: done %0b words %0d wrong %0d err %0b cnt %0d want 1 %0d 0 0 0",
                        done_o, cap_data.size(), bad, err_o, err_cnt_o, NUM_WORDS);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    bit bad_pos [0:255];
    int nbad, placed = 0, p, bad = 0;
    apply_reset();
    for (int i = 0; i < 256; i++) bad_pos[i] = 1'b0;
    nbad = $urandom_range(5, 9);
    while (placed < nbad) begin
      p = $urandom_range(0, 255);
      if (!bad_pos[p]) begin bad_pos[p] = 1'b1; placed++; end
    end
    for (int i = 0; i < NUM_WORDS; i++) push_word(bad_pos[i] ? ($urandom | 32'h100) : 32'(i));
    wait_done(1500, ok);
    @(posedge clk); #1;
    tests_run++; if (!ok || err_cnt_o !== ERR_W'(model_errs(run_base, NUM_WORDS, ERR_W))) begin
      fails++; $display("FAIL sat_wide_count: cnt %0d want %0d", err_cnt_o, model_errs(run_base, NUM_WORDS, ERR_W));
    end
    tests_run++; if (errcnt1 !== 2'(model_errs(run_base, NUM_WORDS, 2)) || err1 !== 1'b1) begin
      fails++; $display("FAIL sat_narrow_count: cnt %0d err %0b want %0d 1", errcnt1, err1, model_errs(run_base, NUM_WORDS, 2));
    end
    for (int k = 0; k < cap_ecnt.size(); k++)
      if (cap_ecnt[k] !== ERR_W'(model_errs(run_base, k + 1, ERR_W))) bad++;
    tests_run++; if (bad != 0 || cap_ecnt.size() != NUM_WORDS) begin
      fails++; $display("FAIL sat_running_count: %0d wrong of %0d want 0 of %0d", bad, cap_ecnt.size(), NUM_WORDS);
    end
    tests_run++; if (done1 !== 1'b1 || addr1 !== '0 || data1 !== mem[run_base + NUM_WORDS - 1] ||
                     valid1_cnt != NUM_WORDS || rdreq1_cnt != NUM_WORDS) begin
      fails++; $display("FAIL sat_narrow_run: done %0b addr %0h data %0h valids %0d reqs %0d want 1 0 %0h %0d %0d",
                        done1, addr1, data1, valid1_cnt, rdreq1_cnt, mem[run_base + NUM_WORDS - 1], NUM_WORDS, NUM_WORDS);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    flush_req = 1'b1;
    hold_empty = 1'b0;
    test_reset();
    test_full_drain();
    test_stall();
    test_corrupt();
    test_done_hold();
    test_mid_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
